// File: rtl/riscv_pkg.sv
// Shared definitions for the kick-up token ring pipeline.
// Fetch state encoding, EBREAK opcode and fault codes.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_EBREAK   = 2'b11;

endpackage

// File: rtl/fetch_watchdog.sv
// Imem wait-cycle counter for the fetch stage.
// o_expire flags the cycle whose increment would reach TIMEOUT.
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch end of the kick-up token ring:
// next-PC select, imem req/ready handshake, IF_kick_up issue.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WB_kick_up,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        IF_kick_up,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_instruction,
  output logic        IF_halted,
  output logic [1:0]  IF_fault
);

  fetch_state_t r_state, w_next;

  logic [31:0] r_pc, w_pc_next, w_npc;
  logic [31:0] r_if_pc, r_instr;
  logic [1:0]  r_fault, w_fault_next;
  logic        w_latch, w_expire;
  logic        w_wd_clr, w_wd_en;

  assign w_wd_clr = (r_state != S_REQ);
  assign w_wd_en  = (r_state == S_REQ) && !imem_ready;

  fetch_watchdog #(
    .TIMEOUT (IMEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next       = r_state;
    w_pc_next    = r_pc;
    w_fault_next = r_fault;
    w_latch      = 1'b0;
    w_npc        = Branch_taken ? Branch_target : r_pc + 32'd4;
    case (r_state)
      S_BOOT:  w_next = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          w_latch = 1'b1;
          w_next  = S_ISSUE;
        end else if (w_expire) begin
          w_next       = S_HALT;
          w_fault_next = FAULT_TIMEOUT;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (WB_kick_up) begin
          if (r_instr == INSTR_EBREAK) begin
            w_next       = S_HALT;
            w_fault_next = FAULT_EBREAK;
          end else if (w_npc[1:0] != 2'b00) begin
            w_next       = S_HALT;
            w_fault_next = FAULT_MISALIGN;
          end else begin
            w_pc_next = w_npc;
            w_next    = S_REQ;
          end
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_if_pc <= '0;
      r_instr <= '0;
      r_fault <= FAULT_NONE;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_fault <= w_fault_next;
      if (w_latch) begin
        r_if_pc <= r_pc;
        r_instr <= imem_rdata;
      end
    end
  end

  // Handshake outputs decode straight from state so reset drops them at once
  assign imem_req       = (r_state == S_REQ);
  assign imem_addr      = imem_req ? r_pc : 32'h0;
  assign IF_kick_up     = (r_state == S_ISSUE);
  assign IF_halted      = (r_state == S_HALT);
  assign IF_pc          = r_if_pc;
  assign IF_instruction = r_instr;
  assign IF_fault       = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps plus
// randomized fetch/branch traffic against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WB_kick_up = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] Branch_target = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        IF_kick_up;
  logic [31:0] IF_pc;
  logic [31:0] IF_instruction;
  logic        IF_halted;
  logic [1:0]  IF_fault;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_halted;
  logic [1:0]  m_fault;

  fetch_stage #(
    .RESET_PC     (RST_PC),
    .IMEM_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .WB_kick_up     (WB_kick_up),
    .Branch_taken   (Branch_taken),
    .Branch_target  (Branch_target),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .IF_kick_up     (IF_kick_up),
    .IF_pc          (IF_pc),
    .IF_instruction (IF_instruction),
    .IF_halted      (IF_halted),
    .IF_fault       (IF_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    if (r == EBREAK) r = 32'h0000_0013;
    return r;
  endfunction

  task automatic stray();
    WB_kick_up    = 1'($urandom);
    Branch_taken  = 1'($urandom);
    Branch_target = $urandom;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_kick", IF_kick_up, 0);
    chk("rst_pc", IF_pc, 0);
    chk("rst_instr", IF_instruction, 0);
    chk("rst_halt", IF_halted, 0);
    chk("rst_fault", IF_fault, 0);
    WB_kick_up = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    m_pc     = RST_PC;
    m_ifpc   = '0;
    m_instr  = '0;
    m_halted = 1'b0;
    m_fault  = 2'b00;
    #1;
    chk("boot_req", imem_req, 0);
    chk("boot_kick", IF_kick_up, 0);
    @(negedge clk);
  endtask

  task automatic do_fetch(input int lat, input logic [31:0] data);
    chk("req", imem_req, 1);
    chk("addr", imem_addr, m_pc);
    for (int i = 0; i < lat; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      stray();
      @(negedge clk);
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, m_pc);
      chk("no_kick", IF_kick_up, 0);
      chk("pc_hold", IF_pc, m_ifpc);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    stray();
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    stray();
    m_ifpc  = m_pc;
    m_instr = data;
    chk("kick", IF_kick_up, 1);
    chk("if_pc", IF_pc, m_ifpc);
    chk("if_instr", IF_instruction, m_instr);
    chk("issue_req", imem_req, 0);
    @(negedge clk);
    WB_kick_up = 1'b0;
    chk("kick_once", IF_kick_up, 0);
    chk("pc_stable", IF_pc, m_ifpc);
    chk("wait_req", imem_req, 0);
  endtask

  task automatic wb(input logic tk, input logic [31:0] tgt, input int idle);
    logic [31:0] npc;
    for (int i = 0; i < idle; i++) begin
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      chk("idle_kick", IF_kick_up, 0);
      chk("idle_req", imem_req, 0);
      chk("idle_pc", IF_pc, m_ifpc);
      chk("idle_instr", IF_instruction, m_instr);
    end
    imem_ready    = 1'b0;
    WB_kick_up    = 1'b1;
    Branch_taken  = tk;
    Branch_target = tgt;
    @(negedge clk);
    WB_kick_up    = 1'b0;
    Branch_taken  = 1'($urandom);
    Branch_target = $urandom;
    npc = tk ? tgt : m_pc + 32'd4;
    if (m_instr == EBREAK) begin
      m_halted = 1'b1;
      m_fault  = 2'b11;
    end else if (npc % 4 != 0) begin
      m_halted = 1'b1;
      m_fault  = 2'b01;
    end else begin
      m_pc = npc;
    end
    chk("halted", IF_halted, m_halted);
    chk("fault", IF_fault, m_fault);
    chk("wb_req", imem_req, m_halted ? 0 : 1);
    chk("wb_addr", imem_addr, m_halted ? 32'h0 : m_pc);
  endtask

  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      stray();
      imem_ready = 1'($urandom);
      @(negedge clk);
      chk("h_halt", IF_halted, 1);
      chk("h_fault", IF_fault, m_fault);
      chk("h_req", imem_req, 0);
      chk("h_addr", imem_addr, 0);
      chk("h_kick", IF_kick_up, 0);
    end
    WB_kick_up = 1'b0;
    imem_ready = 1'b0;
  endtask

  initial begin
    apply_reset();
    do_fetch(0, 32'h0000_0013);

    for (int i = 0; i < 3; i++) begin
      wb(1'b0, $urandom, 0);
      do_fetch(0, rnd_instr());
    end

    wb(1'b1, 32'hFFFF_FFFC, 1);
    do_fetch(0, rnd_instr());
    wb(1'b0, $urandom, 0);
    do_fetch(15, rnd_instr());

    for (int i = 0; i < 25; i++) begin
      wb(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3));
      do_fetch($urandom_range(0, 15), rnd_instr());
    end

    wb(1'b1, 32'h0000_0102, 2);
    halt_idle(4);

    apply_reset();
    for (int i = 0; i < 16; i++) begin
      chk("to_req", imem_req, 1);
      imem_ready = 1'b0;
      @(negedge clk);
    end
    m_halted = 1'b1;
    m_fault  = 2'b10;
    chk("to_halt", IF_halted, 1);
    chk("to_fault", IF_fault, 2'b10);
    halt_idle(3);

    apply_reset();
    do_fetch(1, EBREAK);
    wb(1'b1, 32'h0000_0102, 1);
    halt_idle(3);

    apply_reset();
    do_fetch(0, rnd_instr());
    wb(1'b1, 32'h0000_0400, 0);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_req", imem_req, 1);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    apply_reset();
    chk("rst_stale_kick", IF_kick_up, 0);
    chk("rst_addr0", imem_addr, RST_PC);
    imem_ready = 1'b0;
    @(negedge clk);
    chk("rst_no_kick", IF_kick_up, 0);
    do_fetch(2, rnd_instr());
    wb(1'b0, $urandom, 0);
    do_fetch(0, rnd_instr());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
